// File: rtl/d_cache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache between
// the MEM stage and backing memory, with a line-fill/write-through FSM.
module d_cache_responder #(
    parameter int WORD_SIZE   = 16,
    parameter int OFFSET_BITS = 2,
    parameter int INDEX_BITS  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  d_readC,
    input  logic                                  d_writeC,
    input  logic [WORD_SIZE-1:0]                  d_address,
    input  logic [WORD_SIZE-1:0]                  d_wdata,
    output logic [WORD_SIZE-1:0]                  d_rdata,
    output logic                                  d_ready,
    output logic                                  d_stall,
    output logic                                  mem_readC,
    output logic                                  mem_writeC,
    output logic [WORD_SIZE-1:0]                  mem_address,
    output logic [WORD_SIZE-1:0]                  mem_wdata,
    input  logic [(WORD_SIZE<<OFFSET_BITS)-1:0]   mem_rdata,
    input  logic                                  mem_ack,
    output logic [15:0]                           num_access,
    output logic [15:0]                           num_hit
);

    localparam int TAG_BITS = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        FILL,
        WRITE,
        RESP
    } state_t;

    state_t state;

    logic [WORD_SIZE-1:0] reqAddr;
    logic [WORD_SIZE-1:0] reqData;
    logic                 reqWrite;

    logic [LINES-1:0]     validBits;
    logic [TAG_BITS-1:0]  tagArr  [LINES];
    logic [WORD_SIZE-1:0] dataArr [LINES][WORDS];

    logic [OFFSET_BITS-1:0] reqOffset;
    logic [INDEX_BITS-1:0]  reqIndex;
    logic [TAG_BITS-1:0]    reqTag;
    logic                   hit;
    logic                   fillDone;
    logic                   writeHit;
    logic [WORD_SIZE-1:0]   fillWord;

    assign reqOffset = reqAddr[OFFSET_BITS-1:0];
    assign reqIndex  = reqAddr[OFFSET_BITS +: INDEX_BITS];
    assign reqTag    = reqAddr[WORD_SIZE-1 -: TAG_BITS];

    assign hit      = validBits[reqIndex] && (tagArr[reqIndex] == reqTag);
    assign fillDone = (state == FILL) && mem_ack;
    assign writeHit = (state == TAG) && reqWrite && hit;
    assign fillWord = mem_rdata[int'(reqOffset)*WORD_SIZE +: WORD_SIZE];

    assign d_stall = (d_readC | d_writeC) & ~d_ready;

    // Tag/data storage is deliberately left out of reset; validBits guards it.
    always_ff @(posedge clk) begin
        if (fillDone) begin
            tagArr[reqIndex] <= reqTag;
            for (int w = 0; w < WORDS; w++) begin
                dataArr[reqIndex][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
            end
        end else if (writeHit) begin
            dataArr[reqIndex][reqOffset] <= reqData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            reqAddr     <= '0;
            reqData     <= '0;
            reqWrite    <= 1'b0;
            validBits   <= '0;
            d_rdata     <= '0;
            d_ready     <= 1'b0;
            mem_readC   <= 1'b0;
            mem_writeC  <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            num_access  <= '0;
            num_hit     <= '0;
        end else begin
            d_ready <= 1'b0;
            d_rdata <= '0;
            unique case (state)
                IDLE: begin
                    // The request is still held during the d_ready cycle.
                    if (!d_ready && (d_writeC || d_readC)) begin
                        reqAddr  <= d_address;
                        reqData  <= d_wdata;
                        reqWrite <= d_writeC;
                        state    <= TAG;
                    end
                end
                TAG: begin
                    num_access <= num_access + 16'd1;
                    if (hit) begin
                        num_hit <= num_hit + 16'd1;
                    end
                    if (reqWrite) begin
                        mem_writeC  <= 1'b1;
                        mem_address <= reqAddr;
                        mem_wdata   <= reqData;
                        state       <= WRITE;
                    end else if (hit) begin
                        d_ready <= 1'b1;
                        d_rdata <= dataArr[reqIndex][reqOffset];
                        state   <= IDLE;
                    end else begin
                        mem_readC   <= 1'b1;
                        mem_address <= {reqTag, reqIndex,
                                        {OFFSET_BITS{1'b0}}};
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        validBits[reqIndex] <= 1'b1;
                        mem_readC   <= 1'b0;
                        mem_address <= '0;
                        d_ready     <= 1'b1;
                        d_rdata     <= fillWord;
                        state       <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_writeC  <= 1'b0;
                        mem_address <= '0;
                        mem_wdata   <= '0;
                        d_ready     <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_responder.sv
// Directed vector bench for d_cache_responder: table of CPU transactions
// with a responding memory, plus reset-mid-fill sequence.
module tb_d_cache_responder;

    logic        clk;
    logic        reset_n;
    logic        d_readC;
    logic        d_writeC;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        mem_readC;
    logic        mem_writeC;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] num_access;
    logic [15:0] num_hit;

    int checks = 0;
    int errors = 0;

    d_cache_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_readC     (d_readC),
        .d_writeC    (d_writeC),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .d_stall     (d_stall),
        .mem_readC   (mem_readC),
        .mem_writeC  (mem_writeC),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .num_access  (num_access),
        .num_hit     (num_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        expMem;
        logic        drop;
        int          ackDelay;
        logic [63:0] line;
        logic [15:0] expRdata;
        logic [15:0] expMemAddr;
        logic [15:0] expAcc;
        logic [15:0] expHit;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends on a negedge; returns in the cycle after d_ready.
    task automatic runTxn(input vec_t v, input int idx);
        int    cyc = 0;
        int    waitCnt = 0;
        bit    seenMem = 0;
        bit    done = 0;
        int    expLat;
        string tag;
        tag = $sformatf("v%0d", idx);
        expLat = v.expMem ? 3 + v.ackDelay : 2;
        d_readC   = !v.write;
        d_writeC  = v.write;
        d_address = v.addr;
        d_wdata   = v.wdata;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (cyc == 1) begin
                chk({tag, "_stall"}, d_stall, 1'b1);
                chk({tag, "_rdata_idle"}, d_rdata, 16'h0);
            end
            if (d_ready) begin
                done = 1;
                chk({tag, "_lat"}, cyc, expLat);
                chk({tag, "_rdata"}, d_rdata, v.expRdata);
                chk({tag, "_memreq"}, seenMem, v.expMem);
                chk({tag, "_acc"}, num_access, v.expAcc);
                chk({tag, "_hit"}, num_hit, v.expHit);
            end else if (mem_readC || mem_writeC) begin
                if (!seenMem) begin
                    chk({tag, "_mrd"}, mem_readC, !v.write);
                    chk({tag, "_mwr"}, mem_writeC, v.write);
                    chk({tag, "_maddr"}, mem_address, v.expMemAddr);
                    if (v.write) begin
                        chk({tag, "_mwdata"}, mem_wdata, v.wdata);
                    end
                    if (v.drop) begin
                        d_readC  = 1'b0;
                        d_writeC = 1'b0;
                    end
                end
                seenMem = 1;
                if (waitCnt == v.ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.line;
                end
                waitCnt++;
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end
        mem_ack  = 1'b0;
        d_readC  = 1'b0;
        d_writeC = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, d_ready, 1'b0);
        chk({tag, "_rdata0"}, d_rdata, 16'h0);
    endtask

    task automatic resetMidFill();
        int cyc = 0;
        d_readC   = 1'b1;
        d_address = 16'h0038;
        while (!mem_readC && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_fill_seen", mem_readC, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mrd_drop", mem_readC, 1'b0);
        chk("rst_maddr", mem_address, 16'h0);
        chk("rst_acc", num_access, 16'h0);
        d_readC = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_ready", d_ready, 1'b0);
        chk("late_ack_mrd", mem_readC, 1'b0);
    endtask

    localparam logic [63:0] L1 = {16'h00D3, 16'h00C2, 16'h00B1, 16'h00A0};
    localparam logic [63:0] L2 = {16'h1113, 16'h1112, 16'h1111, 16'h1110};
    localparam logic [63:0] L3 = {16'h00D3, 16'h00C2, 16'hBEEF, 16'h00A0};
    localparam logic [63:0] L4 = {16'h0004, 16'h0003, 16'h0002, 16'h1234};
    localparam logic [63:0] L5 = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
    localparam logic [63:0] L6 = {16'h3003, 16'h3002, 16'h3001, 16'h3000};

    initial begin
        vecs[0]  = '{0, 16'h0012, 16'h0, 1, 0, 3, L1,
                     16'h00C2, 16'h0010, 16'd1, 16'd0};
        vecs[1]  = '{0, 16'h0013, 16'h0, 0, 0, 0, 64'h0,
                     16'h00D3, 16'h0, 16'd2, 16'd1};
        vecs[2]  = '{1, 16'h0011, 16'hBEEF, 1, 0, 1, 64'h0,
                     16'h0000, 16'h0011, 16'd3, 16'd2};
        vecs[3]  = '{0, 16'h0011, 16'h0, 0, 0, 0, 64'h0,
                     16'hBEEF, 16'h0, 16'd4, 16'd3};
        vecs[4]  = '{0, 16'h0010, 16'h0, 0, 0, 0, 64'h0,
                     16'h00A0, 16'h0, 16'd5, 16'd4};
        vecs[5]  = '{0, 16'h0052, 16'h0, 1, 0, 0, L2,
                     16'h1112, 16'h0050, 16'd6, 16'd4};
        vecs[6]  = '{0, 16'h0012, 16'h0, 1, 0, 2, L3,
                     16'h00C2, 16'h0010, 16'd7, 16'd4};
        vecs[7]  = '{1, 16'h0100, 16'h1234, 1, 0, 0, 64'h0,
                     16'h0000, 16'h0100, 16'd8, 16'd4};
        vecs[8]  = '{0, 16'h0100, 16'h0, 1, 0, 0, L4,
                     16'h1234, 16'h0100, 16'd9, 16'd4};
        vecs[9]  = '{0, 16'h0025, 16'h0, 1, 0, 1, L5,
                     16'h2001, 16'h0024, 16'd10, 16'd4};
        vecs[10] = '{0, 16'h0103, 16'h0, 0, 0, 0, 64'h0,
                     16'h0004, 16'h0, 16'd11, 16'd5};
        vecs[11] = '{0, 16'h0027, 16'h0, 0, 0, 0, 64'h0,
                     16'h2003, 16'h0, 16'd12, 16'd6};
        vecs[12] = '{0, 16'h0038, 16'h0, 1, 0, 1, L6,
                     16'h3000, 16'h0038, 16'd1, 16'd0};
        vecs[13] = '{0, 16'h0103, 16'h0, 1, 0, 0, L4,
                     16'h0004, 16'h0100, 16'd2, 16'd0};
        vecs[14] = '{1, 16'h0200, 16'h5555, 1, 1, 1, 64'h0,
                     16'h0000, 16'h0200, 16'd3, 16'd0};
        vecs[15] = '{0, 16'h003B, 16'h0, 0, 0, 0, 64'h0,
                     16'h3003, 16'h0, 16'd4, 16'd1};

        reset_n   = 1'b0;
        d_readC   = 1'b0;
        d_writeC  = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", d_ready, 1'b0);
        chk("rst_rdata", d_rdata, 16'h0);
        chk("rst_stall", d_stall, 1'b0);
        chk("rst_mrd", mem_readC, 1'b0);
        chk("rst_mwr", mem_writeC, 1'b0);
        chk("rst_maddr0", mem_address, 16'h0);
        chk("rst_mwdata", mem_wdata, 16'h0);
        chk("rst_access", num_access, 16'h0);
        chk("rst_hits", num_hit, 16'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            runTxn(vecs[i], i);
        end
        resetMidFill();
        for (int i = 12; i < 16; i++) begin
            runTxn(vecs[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
